range_stats: RTL

RANGE_STATS -- requirements
Module: range_stats

---
 rtl/range_stats.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/range_stats.sv
// Frame statistics engine: tracks min, max and sample count over a go..finish
// frame and reports range, min, max or midpoint once the frame is closed.
module range_stats #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             go,
  input  logic             finish,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             busy,
  output logic             sat,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] min_r, max_r, min_s, max_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             sat_r, sat_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] mid_s, range_s;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] ka;
    logic [WIDTH-1:0] kb;
    ka = a;
    kb = b;
    if (SIGNED != 0) begin
      ka[WIDTH-1] = ~a[WIDTH-1];
      kb[WIDTH-1] = ~b[WIDTH-1];
    end else begin
      ka = a;
      kb = b;
    end
    return (ka < kb);
  endfunction

  function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] a);
    return (SIGNED != 0) ? {a[WIDTH-1], a} : {1'b0, a};
  endfunction

  // State and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      min_r   <= W_ZERO;
      max_r   <= W_ZERO;
      count_r <= CNT_ZERO;
      sat_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      min_r   <= min_s;
      max_r   <= max_s;
      count_r <= count_s;
      sat_r   <= sat_s;
    end
  end

  // Next-state and statistics update.
  always_comb begin
    state_s = state_r;
    min_s   = min_r;
    max_s   = max_r;
    count_s = count_r;
    sat_s   = sat_r;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (go && !finish) begin
          state_s = RUN;
          min_s   = data_in;
          max_s   = data_in;
          count_s = CNT_ONE;
          sat_s   = 1'b0;
        end else if (go && finish && (state_r != ERR)) begin
          state_s = ERR;
          min_s   = W_ZERO;
          max_s   = W_ZERO;
          count_s = CNT_ZERO;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (go) begin
          state_s = ERR;
          min_s   = W_ZERO;
          max_s   = W_ZERO;
          count_s = CNT_ZERO;
        end else begin
          if (less_than(data_in, min_r)) begin
            min_s = data_in;
          end else begin
            min_s = min_r;
          end
          if (less_than(max_r, data_in)) begin
            max_s = data_in;
          end else begin
            max_s = max_r;
          end
          if (count_r == CNT_MAX) begin
            sat_s = 1'b1;
          end else begin
            count_s = count_r + CNT_ONE;
          end
          if (finish) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // max >= min always holds, so the plain difference cannot wrap.
  assign range_s = max_r - min_r;
  assign sum_s   = extend(min_r) + extend(max_r);
  assign mid_s   = WIDTH'(sum_s >> 1);

  // Result mux, forced to zero whenever no finished frame is held.
  always_comb begin
    result = W_ZERO;
    if (state_r == DONE) begin
      case (sel)
        2'b00:   result = range_s;
        2'b01:   result = min_r;
        2'b10:   result = max_r;
        2'b11:   result = mid_s;
        default: result = W_ZERO;
      endcase
    end else begin
      result = W_ZERO;
    end
  end

  assign count = ((state_r == RUN) || (state_r == DONE)) ? count_r : CNT_ZERO;
  assign valid = (state_r == DONE);
  assign busy  = (state_r == RUN);
  assign error = (state_r == ERR);
  assign sat   = sat_r;

endmodule
